kernel_conv_sequencer: RTL and testbench
========================================

Name: kernel_conv_sequencer

Overview:
Initiator side of the kernel-accumulator handshake. It runs one full SIZE x SIZE window convolution per `go`:
- clears the accumulator;
- walks the kernel index (x fastest, then y);
- fetches pixel and coefficient operands and issues one `acc_start` per element;
- captures the final 8-bit sum.

It holds the kernel coefficients in an internal register file and sits between the window/line-buffer logic and the accumulator.

Parameters:
SIZE, 3, kernel dimension; N = SIZE*SIZE elements (SIZE 1..15)
TIMEOUT, 15, max cycles to wait for acc_clear_flag or acc_ready before error

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
go  in  1  start one convolution; sampled only in IDLE
k_wr_en  in  1  coefficient write strobe
k_wr_addr  in  8  coefficient index (y*SIZE+x); writes with addr >= N dropped
k_wr_data  in  8  coefficient value (unsigned Q0.8)
pix_x  out  4  current window x offset
pix_y  out  4  current window y offset
pix_data  in  8  pixel at (pix_x, pix_y); combinational, same cycle
acc_kernel_v  out  8  coefficient[idx] (combinational from regfile)
acc_pixel_v  out  8  pix_data passed through
acc_clear  out  1  accumulator clear request
acc_start  out  1  accumulator multiply-accumulate request
acc_ready  in  1  accumulator accumulate-complete (1-cycle pulse)
acc_clear_flag  in  1  accumulator clear-complete (1-cycle pulse)
acc_sum  in  8  accumulator result
busy  out  1  high in every state except IDLE
result  out  8  last captured sum; holds until next capture
result_valid  out  1  1-cycle pulse on capture
error  out  1  1-cycle pulse on timeout

Behaviour:
- Reset values: all outputs 0; state IDLE; idx = 0; timeout counter = 0; all coefficients 0.
- States: IDLE, CLEAR, WAIT_CLR, ISSUE, WAIT_RDY, DONE.
- IDLE:
  - go=1 -> CLEAR.
  - k_wr_en is accepted only in IDLE; ignored in every other state.
  - If k_wr_en and go arrive together, the write happens and the run uses the new value.
- CLEAR: acc_clear=1 for exactly 1 cycle -> WAIT_CLR.
- WAIT_CLR:
  - acc_clear_flag=1 -> ISSUE, idx=0.
  - Timeout counter reaches TIMEOUT -> error pulse, go to IDLE.
- ISSUE: acc_start=1 for 1 cycle -> WAIT_RDY. idx is held, so the operands stay valid during the next cycle, in which the accumulator samples them.
- WAIT_RDY, on acc_ready=1:
  - If idx == N-1: register result <= acc_sum -> DONE.
  - Else: idx++ and acc_start=1 in the same cycle (combinational on acc_ready); stay in WAIT_RDY. The new operands are valid from the next cycle.
- WAIT_RDY timeout: counter reaches TIMEOUT -> error, IDLE. Result is unchanged.
- DONE: result_valid=1 for 1 cycle -> IDLE.
- Timeout counter:
  - resets on entry to WAIT_CLR and WAIT_RDY, and on every acc_ready;
  - counts cycles spent waiting;
  - error fires when count == TIMEOUT.
- Index counter: pix_x wraps SIZE-1 -> 0 and increments pix_y. idx = pix_y*SIZE + pix_x.
- acc_kernel_v = coef[idx] and acc_pixel_v = pix_data in all states. Both are only meaningful the cycle after acc_start.
- Latency (go sampled high at edge 0):
  - CLEAR in cycle 1, ISSUE in cycle 3.
  - acc_ready for element k at cycle 5+2k.
  - result_valid at cycle 4+2N (22 for SIZE=3).
- go while busy: ignored. acc_ready/acc_clear_flag in unexpected states: ignored.
- Reset mid-run: immediately back to IDLE and coefficients cleared. No result_valid or error pulse.
- The 16-bit accumulation wraps inside the accumulator; this block does no arithmetic beyond index math.

Decomposition:
- Package kernel_pkg holds:
  - seq_state_t enum (3-bit);
  - function KERNEL_N(SIZE);
  - COEF_W = 8, IDX_W = 8.
- One sub-module, kernel_coef_regfile: N x 8 registers, synchronous write, combinational read, async reset to 0.

Test Plan:
- Load all coef=0x20, pix_data=0x80 always, pulse go -> 9 acc_start pulses, result_valid at cycle 22, result=0x90.
- All coef=0xFF, pix=0xFF -> result=0xEE (9*0xFE01 wraps to 0xEE09).
- Only coef[4]=0xFF (others 0), pix_data=0x64 at (1,1), 0x11 elsewhere -> result=0x63; pix_x/pix_y sequence (0,0),(1,0),(2,0),(0,1)...(2,2).
- Accumulator model holds acc_ready low after element 3 -> error pulses 15 cycles later, busy drops, result unchanged, no result_valid.
- k_wr_en and go asserted mid-run -> both ignored; the run completes with the old coefficients.
- n_rst asserted during WAIT_RDY -> next cycle busy=0, result=0, all coefficients read 0; a following go completes normally.

Source files
------------

// File: rtl/kernel_pkg.sv
// Shared types and sizing for the kernel convolution sequencer slice.
`timescale 1ns/1ps
package kernel_pkg;

    localparam int unsigned COEF_W = 8;
    localparam int unsigned IDX_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_CLR,
        S_ISSUE,
        S_WAIT_RDY,
        S_DONE
    } seq_state_t;

    function automatic int unsigned KERNEL_N(input int unsigned size);
        return size * size;
    endfunction

endpackage

// File: rtl/kernel_coef_regfile.sv
// Kernel coefficient store: synchronous write, combinational read, async clear.
`timescale 1ns/1ps
module kernel_coef_regfile
    import kernel_pkg::*;
#(
    parameter int unsigned N = 9
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [COEF_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [COEF_W-1:0] rd_data
);

    localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;

    // Array is padded to a power of two so the address slice indexes it exactly;
    // entries at N and above are never written and stay zero.
    logic [COEF_W-1:0] coef_q [2**AW];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int unsigned i = 0; i < 2**AW; i++) begin
                coef_q[i] <= '0;
            end
        end else if (wr_en && (wr_addr < IDX_W'(N))) begin
            coef_q[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = coef_q[rd_addr[AW-1:0]];

endmodule

// File: rtl/kernel_conv_sequencer.sv
// Drives one SIZE x SIZE window through the kernel accumulator per go pulse.
`timescale 1ns/1ps
module kernel_conv_sequencer
    import kernel_pkg::*;
#(
    parameter int unsigned SIZE    = 3,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              go,
    input  logic              k_wr_en,
    input  logic [IDX_W-1:0]  k_wr_addr,
    input  logic [COEF_W-1:0] k_wr_data,
    output logic [3:0]        pix_x,
    output logic [3:0]        pix_y,
    input  logic [7:0]        pix_data,
    output logic [COEF_W-1:0] acc_kernel_v,
    output logic [7:0]        acc_pixel_v,
    output logic              acc_clear,
    output logic              acc_start,
    input  logic              acc_ready,
    input  logic              acc_clear_flag,
    input  logic [7:0]        acc_sum,
    output logic              busy,
    output logic [7:0]        result,
    output logic              result_valid,
    output logic              error
);

    localparam int unsigned N  = KERNEL_N(SIZE);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    seq_state_t      state_q, state_d;
    logic [3:0]      x_q, x_d;
    logic [3:0]      y_q, y_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      result_q, result_d;
    logic [IDX_W-1:0] idx;
    logic            last_elem;
    logic            timed_out;

    assign idx       = IDX_W'(y_q) * IDX_W'(SIZE) + IDX_W'(x_q);
    assign last_elem = (x_q == 4'(SIZE - 1)) && (y_q == 4'(SIZE - 1));
    // tmo_q counts completed waiting cycles, so the TIMEOUT-th waiting cycle errors.
    assign timed_out = (tmo_q == TW'(TIMEOUT - 1));

    kernel_coef_regfile #(
        .N (N)
    ) u_coef (
        .clk     (clk),
        .n_rst   (n_rst),
        .wr_en   (k_wr_en && (state_q == S_IDLE)),
        .wr_addr (k_wr_addr),
        .wr_data (k_wr_data),
        .rd_addr (idx),
        .rd_data (acc_kernel_v)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            tmo_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            tmo_q    <= tmo_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        tmo_d        = tmo_q;
        result_d     = result_q;
        acc_clear    = 1'b0;
        acc_start    = 1'b0;
        result_valid = 1'b0;
        error        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (go) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                acc_clear = 1'b1;
                tmo_d     = '0;
                state_d   = S_WAIT_CLR;
            end
            S_WAIT_CLR: begin
                if (acc_clear_flag) begin
                    x_d     = '0;
                    y_d     = '0;
                    state_d = S_ISSUE;
                end else if (timed_out) begin
                    error   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_ISSUE: begin
                acc_start = 1'b1;
                tmo_d     = '0;
                state_d   = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (acc_ready) begin
                    tmo_d = '0;
                    if (last_elem) begin
                        result_d = acc_sum;
                        state_d  = S_DONE;
                    end else begin
                        // Next element is requested on the ready cycle itself.
                        acc_start = 1'b1;
                        if (x_q == 4'(SIZE - 1)) begin
                            x_d = '0;
                            y_d = y_q + 4'd1;
                        end else begin
                            x_d = x_q + 4'd1;
                        end
                    end
                end else if (timed_out) begin
                    error   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DONE: begin
                result_valid = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign acc_pixel_v = pix_data;
    assign result      = result_q;

endmodule

// File: tb/tb_kernel_conv_sequencer.sv
// Directed bench for kernel_conv_sequencer with a behavioural accumulator peer.
`timescale 1ns/1ps
module tb_kernel_conv_sequencer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       go;
    logic       k_wr_en;
    logic [7:0] k_wr_addr;
    logic [7:0] k_wr_data;
    logic [3:0] pix_x, pix_y;
    logic [7:0] pix_data;
    logic [7:0] acc_kernel_v, acc_pixel_v;
    logic       acc_clear, acc_start;
    logic       acc_ready, acc_clear_flag;
    logic [7:0] acc_sum;
    logic       busy;
    logic [7:0] result;
    logic       result_valid, error;

    always #5 clk = ~clk;

    kernel_conv_sequencer #(.SIZE(3), .TIMEOUT(15)) dut (
        .clk(clk), .n_rst(n_rst), .go(go),
        .k_wr_en(k_wr_en), .k_wr_addr(k_wr_addr), .k_wr_data(k_wr_data),
        .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .acc_kernel_v(acc_kernel_v), .acc_pixel_v(acc_pixel_v),
        .acc_clear(acc_clear), .acc_start(acc_start),
        .acc_ready(acc_ready), .acc_clear_flag(acc_clear_flag), .acc_sum(acc_sum),
        .busy(busy), .result(result), .result_valid(result_valid), .error(error)
    );

    // Pixel source
    logic       pmode;
    logic [7:0] pconst;
    always_comb begin
        pix_data = pconst;
        if (pmode) pix_data = (pix_x == 4'd1 && pix_y == 4'd1) ? 8'h64 : 8'h11;
    end

    // Accumulator peer: clear flag one cycle after acc_clear; operands sampled the
    // cycle after acc_start; ready (with updated sum) the cycle after that.
    logic [15:0] m_sum = '0;
    logic        m_samp = 1'b0;
    logic        m_ready = 1'b0;
    logic        m_flag = 1'b0;
    int          m_cnt = 0;
    int          stall_lim = 99;
    logic        clr_en = 1'b1;
    logic [3:0]  rec_x [16];
    logic [3:0]  rec_y [16];
    logic [7:0]  rec_k [16];

    always @(posedge clk) begin
        m_flag <= acc_clear && clr_en;
        m_samp <= acc_start;
        m_ready <= m_samp && (m_cnt < stall_lim);
        if (acc_clear) begin
            m_sum <= '0;
            m_cnt <= 0;
        end else if (m_samp) begin
            m_sum <= m_sum + 16'(acc_kernel_v) * 16'(acc_pixel_v);
            if (m_cnt < 16) begin
                rec_x[m_cnt] <= pix_x;
                rec_y[m_cnt] <= pix_y;
                rec_k[m_cnt] <= acc_kernel_v;
            end
            m_cnt <= m_cnt + 1;
        end
    end
    assign acc_ready      = m_ready;
    assign acc_clear_flag = m_flag;
    assign acc_sum        = m_sum[15:8];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic write_coef(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        k_wr_en = 1'b1; k_wr_addr = a; k_wr_data = d;
        @(negedge clk);
        k_wr_en = 1'b0;
    endtask

    task automatic load_coefs(input logic [7:0] fill, input logic [7:0] c4);
        for (int i = 0; i < 9; i++) write_coef(8'(i), (i == 4) ? c4 : fill);
    endtask

    // Cycle k observed at the negedge after edge k-1; go is sampled at edge 0.
    task automatic run_conv(input logic wr_go, input logic [7:0] wr_d, input logic inject,
                            output int valid_cyc, output int err_cyc, output int starts,
                            output int end_cyc, output int valids);
        valid_cyc = -1; err_cyc = -1; starts = 0; end_cyc = -1; valids = 0;
        @(negedge clk);
        go = 1'b1;
        if (wr_go) begin k_wr_en = 1'b1; k_wr_addr = 8'd0; k_wr_data = wr_d; end
        @(posedge clk);
        #1 go = 1'b0; k_wr_en = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (acc_start) starts++;
            if (result_valid) begin valid_cyc = k; valids++; end
            if (error) err_cyc = k;
            if (inject && k == 8) begin
                go = 1'b1; k_wr_en = 1'b1; k_wr_addr = 8'd8; k_wr_data = 8'hFF;
            end
            if (inject && k == 9) begin go = 1'b0; k_wr_en = 1'b0; end
            if (!busy) begin end_cyc = k; break; end
        end
        if (end_cyc < 0) begin
            checks++; failures++;
            $display("FAIL run_bound actual=busy expected=idle within 80 cycles");
        end
    endtask

    typedef struct {
        logic [7:0] fill;
        logic [7:0] c4;
        logic       pmode;
        logic [7:0] pconst;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [4];
    int vc, ec, st, en, nv;

    task automatic check_normal(input string tag, input logic [7:0] exp_res);
        check({tag, "_result"}, int'(result), int'(exp_res));
        check({tag, "_valid_cyc"}, vc, 22);
        check({tag, "_valid_cnt"}, nv, 1);
        check({tag, "_starts"}, st, 9);
        check({tag, "_end_cyc"}, en, 23);
        check({tag, "_no_err"}, ec, -1);
    endtask

    initial begin
        n_rst = 1'b0; go = 1'b0; k_wr_en = 1'b0; k_wr_addr = '0; k_wr_data = '0;
        pmode = 1'b0; pconst = 8'h80;

        vecs[0] = '{fill: 8'h20, c4: 8'h20, pmode: 1'b0, pconst: 8'h80, exp: 8'h90};
        vecs[1] = '{fill: 8'hFF, c4: 8'hFF, pmode: 1'b0, pconst: 8'hFF, exp: 8'hEE};
        vecs[2] = '{fill: 8'h00, c4: 8'hFF, pmode: 1'b1, pconst: 8'h00, exp: 8'h63};
        vecs[3] = '{fill: 8'h10, c4: 8'h10, pmode: 1'b0, pconst: 8'h40, exp: 8'h24};

        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_result", int'(result), 0);
        check("rst_strobes", int'({result_valid, error, acc_clear, acc_start}), 0);
        check("rst_pix_xy", int'({pix_x, pix_y}), 0);
        check("rst_kernel_v", int'(acc_kernel_v), 0);
        check("rst_pixel_v", int'(acc_pixel_v), 8'h80);
        n_rst = 1'b1;

        for (int v = 0; v < 4; v++) begin
            pmode = vecs[v].pmode; pconst = vecs[v].pconst;
            load_coefs(vecs[v].fill, vecs[v].c4);
            run_conv(1'b0, 8'h00, 1'b0, vc, ec, st, en, nv);
            check_normal($sformatf("vec%0d", v), vecs[v].exp);
            for (int i = 0; i < 9; i++) begin
                check($sformatf("vec%0d_x%0d", v, i), int'(rec_x[i]), i % 3);
                check($sformatf("vec%0d_y%0d", v, i), int'(rec_y[i]), i / 3);
                check($sformatf("vec%0d_k%0d", v, i), int'(rec_k[i]),
                      int'((i == 4) ? vecs[v].c4 : vecs[v].fill));
            end
        end

        // Write together with go: coef[0]=0xA0 is used by this run.
        pmode = 1'b0; pconst = 8'h80;
        load_coefs(8'h20, 8'h20);
        run_conv(1'b1, 8'hA0, 1'b0, vc, ec, st, en, nv);
        check_normal("wr_go", 8'hD0);

        // go and a write to coef[8] mid-run are ignored; an out-of-range write is dropped.
        run_conv(1'b0, 8'h00, 1'b1, vc, ec, st, en, nv);
        check_normal("inject", 8'hD0);
        write_coef(8'd13, 8'hFF);
        run_conv(1'b0, 8'h00, 1'b0, vc, ec, st, en, nv);
        check_normal("after_inject", 8'hD0);

        // acc_ready withheld after element 3.
        stall_lim = 4;
        run_conv(1'b0, 8'h00, 1'b0, vc, ec, st, en, nv);
        check("stall_err_cyc", ec, 26);
        check("stall_end_cyc", en, 27);
        check("stall_starts", st, 5);
        check("stall_no_valid", nv, 0);
        check("stall_result", int'(result), 8'hD0);
        check("stall_err_gone", int'(error), 0);
        stall_lim = 99;

        // acc_clear_flag never arrives.
        clr_en = 1'b0;
        run_conv(1'b0, 8'h00, 1'b0, vc, ec, st, en, nv);
        check("clr_err_cyc", ec, 16);
        check("clr_end_cyc", en, 17);
        check("clr_starts", st, 0);
        check("clr_result", int'(result), 8'hD0);
        clr_en = 1'b1;

        // Asynchronous reset during WAIT_RDY.
        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        repeat (8) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("mrst_busy_now", int'(busy), 0);
        @(negedge clk);
        check("mrst_busy", int'(busy), 0);
        check("mrst_result", int'(result), 0);
        check("mrst_strobes", int'({result_valid, error, acc_start}), 0);
        n_rst = 1'b1;
        pconst = 8'hFF;
        run_conv(1'b0, 8'h00, 1'b0, vc, ec, st, en, nv);
        check_normal("post_rst", 8'h00);
        for (int i = 0; i < 9; i++) check($sformatf("post_rst_k%0d", i), int'(rec_k[i]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
